// File: rtl/seq_chain_checker.sv
// seq_chain_checker: launches "attempts" on trig and walks each one along the
// monitored vector, one bit per cycle. Every chain position holds its own
// attempt, so overlapping attempts are tracked independently. The block
// reports pass and fail pulses, saturating event counts, and a sticky capture
// of the step where the first failure happened.
module seq_chain_checker #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     trig,
  input  logic [WIDTH-1:0]         vect,
  output logic                     pass,
  output logic                     fail,
  output logic [$clog2(WIDTH):0]   fail_step,
  output logic                     busy,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     first_fail_vld,
  output logic [$clog2(WIDTH):0]   first_fail_step
);

  localparam int SW = $clog2(WIDTH) + 1;

  // Reject parameter values the chain cannot be built for.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("seq_chain_checker: WIDTH must be in 1..32");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("seq_chain_checker: MODE must be 0 or 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_chain_checker: CNT_W must be at least 1");
    end
  endgenerate

  // Per-step view of the chain: w_live[k] is the attempt sitting at step k,
  // w_bit[k] is the vector bit that step k inspects.
  logic [WIDTH-1:0] w_live;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_ok;
  logic [WIDTH-1:0] w_fail;
  logic             w_pass_n;
  logic             w_fail_n;
  logic [SW-1:0]    w_fstep;

  // Step 0 is the launch itself, so it is checked in the launch cycle.
  assign w_live[0] = trig & en & ~clr;

  genvar gi;
  generate
    // Map each step to its vector bit according to the chain order.
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      localparam int B = (MODE == 1) ? gi : (WIDTH - 1 - gi);
      assign w_bit[gi] = vect[B];
    end

    if (WIDTH > 1) begin : g_chain
      logic [WIDTH-1:1] r_live;

      // Advance surviving attempts one step per cycle; failed ones drop out.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          r_live <= '0;
        end else begin
          r_live <= w_ok[WIDTH-2:0];
        end
      end

      assign w_live[WIDTH-1:1] = r_live;
      assign busy              = |r_live;
    end else begin : g_single
      // A one-step chain never holds an attempt across a clock edge.
      assign busy = 1'b0;
    end
  endgenerate

  assign w_ok     = w_live & w_bit;
  assign w_fail   = w_live & ~w_bit;
  assign w_pass_n = w_ok[WIDTH-1];
  assign w_fail_n = |w_fail;

  // Highest failing step wins: it belongs to the oldest failing attempt.
  always_comb begin
    w_fstep = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (w_fail[k]) begin
        w_fstep = SW'(k);
      end
    end
  end

  logic                r_pass;
  logic                r_fail;
  logic [SW-1:0]       r_fail_step;
  logic [CNT_W-1:0]    r_pass_cnt;
  logic [CNT_W-1:0]    r_fail_cnt;
  logic                r_ffv;
  logic [SW-1:0]       r_ffs;

  // Result pulses, saturating counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_step <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_ffv       <= 1'b0;
      r_ffs       <= '0;
    end else if (clr) begin
      // fail_step keeps its last value; everything else restarts.
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_ffv       <= 1'b0;
      r_ffs       <= '0;
    end else begin
      r_pass <= w_pass_n;
      r_fail <= w_fail_n;
      if (w_fail_n) begin
        r_fail_step <= w_fstep;
      end
      if (w_pass_n && (r_pass_cnt != {CNT_W{1'b1}})) begin
        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      end
      if (w_fail_n && (r_fail_cnt != {CNT_W{1'b1}})) begin
        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      end
      if (w_fail_n && !r_ffv) begin
        r_ffv <= 1'b1;
        r_ffs <= w_fstep;
      end
    end
  end

  assign pass            = r_pass;
  assign fail            = r_fail;
  assign fail_step       = r_fail_step;
  assign pass_cnt        = r_pass_cnt;
  assign fail_cnt        = r_fail_cnt;
  assign first_fail_vld  = r_ffv;
  assign first_fail_step = r_ffs;

endmodule

// File: tb/tb_seq_chain_checker.sv
// tb_seq_chain_checker: three checker instances (4-bit descending with 2-bit
// counters, 4-bit ascending, 1-bit) share one stimulus stream. A reference
// model tracks attempts as a list of ages and predicts every output for the
// next cycle; predictions go into a queue that a monitor drains and compares.
module tb_seq_chain_checker;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic [2:0]  fstep;
    logic        busy;
    logic [15:0] pcnt;
    logic [15:0] fcnt;
    logic        ffv;
    logic [2:0]  ffs;
  } exp_t;

  typedef exp_t [2:0] row_t;

  localparam int W_I  [3] = '{4, 4, 1};
  localparam int M_I  [3] = '{0, 1, 0};
  localparam int CMAX [3] = '{3, 65535, 65535};

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       trig;
  logic [3:0] vect;

  logic        a_pass, a_fail, a_busy, a_ffv;
  logic [2:0]  a_fstep, a_ffs;
  logic [1:0]  a_pcnt, a_fcnt;
  logic        b_pass, b_fail, b_busy, b_ffv;
  logic [2:0]  b_fstep, b_ffs;
  logic [15:0] b_pcnt, b_fcnt;
  logic        c_pass, c_fail, c_busy, c_ffv;
  logic [0:0]  c_fstep, c_ffs;
  logic [15:0] c_pcnt, c_fcnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle_no = 0;

  row_t sb_q [$];
  exp_t m    [3];
  int   ages [3][$];
  exp_t act  [3];

  seq_chain_checker #(.WIDTH(4), .MODE(0), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .vect(vect),
    .pass(a_pass), .fail(a_fail), .fail_step(a_fstep), .busy(a_busy),
    .pass_cnt(a_pcnt), .fail_cnt(a_fcnt),
    .first_fail_vld(a_ffv), .first_fail_step(a_ffs)
  );

  seq_chain_checker #(.WIDTH(4), .MODE(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .vect(vect),
    .pass(b_pass), .fail(b_fail), .fail_step(b_fstep), .busy(b_busy),
    .pass_cnt(b_pcnt), .fail_cnt(b_fcnt),
    .first_fail_vld(b_ffv), .first_fail_step(b_ffs)
  );

  seq_chain_checker #(.WIDTH(1), .MODE(0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .vect(vect[0:0]),
    .pass(c_pass), .fail(c_fail), .fail_step(c_fstep), .busy(c_busy),
    .pass_cnt(c_pcnt), .fail_cnt(c_fcnt),
    .first_fail_vld(c_ffv), .first_fail_step(c_ffs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Gather the DUT outputs into the same shape as the predictions.
  always_comb begin
    act[0] = '{pass: a_pass, fail: a_fail, fstep: a_fstep, busy: a_busy,
               pcnt: {14'b0, a_pcnt}, fcnt: {14'b0, a_fcnt},
               ffv: a_ffv, ffs: a_ffs};
    act[1] = '{pass: b_pass, fail: b_fail, fstep: b_fstep, busy: b_busy,
               pcnt: b_pcnt, fcnt: b_fcnt, ffv: b_ffv, ffs: b_ffs};
    act[2] = '{pass: c_pass, fail: c_fail, fstep: {2'b0, c_fstep}, busy: c_busy,
               pcnt: c_pcnt, fcnt: c_fcnt, ffv: c_ffv, ffs: {2'b0, c_ffs}};
  end

  // Reference model: each attempt is an age; age k inspects its chain bit.
  task automatic model_step(input int i, input logic r, input logic c,
                            input logic e, input logic t, input logic [3:0] v);
    int   nxt [$];
    int   w;
    int   a;
    int   b;
    int   fs;
    logic p;
    logic f;
    w = W_I[i];
    if (r) begin
      ages[i].delete();
      m[i] = '0;
    end else if (c) begin
      ages[i].delete();
      m[i].pass = 1'b0;
      m[i].fail = 1'b0;
      m[i].pcnt = '0;
      m[i].fcnt = '0;
      m[i].ffv  = 1'b0;
      m[i].ffs  = '0;
    end else begin
      p  = 1'b0;
      f  = 1'b0;
      fs = 0;
      if (t && e) ages[i].push_back(0);
      foreach (ages[i][j]) begin
        a = ages[i][j];
        b = (M_I[i] == 1) ? a : (w - 1 - a);
        if (v[b]) begin
          if (a == w - 1) p = 1'b1;
          else nxt.push_back(a + 1);
        end else begin
          f = 1'b1;
          if (a > fs) fs = a;
        end
      end
      ages[i] = nxt;
      m[i].pass = p;
      m[i].fail = f;
      if (f) m[i].fstep = 3'(fs);
      if (p && (int'(m[i].pcnt) < CMAX[i])) m[i].pcnt = m[i].pcnt + 16'd1;
      if (f && (int'(m[i].fcnt) < CMAX[i])) m[i].fcnt = m[i].fcnt + 16'd1;
      if (f && !m[i].ffv) begin
        m[i].ffv = 1'b1;
        m[i].ffs = 3'(fs);
      end
    end
    m[i].busy = (ages[i].size() != 0);
  endtask

  // Drive one cycle of inputs and queue the predicted outputs for it.
  task automatic cyc(input logic r, input logic c, input logic e,
                     input logic t, input logic [3:0] v);
    row_t row;
    @(negedge clk);
    rst  = r;
    clr  = c;
    en   = e;
    trig = t;
    vect = v;
    cycle_no++;
    for (int i = 0; i < 3; i++) begin
      model_step(i, r, c, e, t, v);
      row[i] = m[i];
    end
    sb_q.push_back(row);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
  endtask

  // Monitor: after each rising edge, compare every instance to its prediction.
  initial begin : monitor
    row_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          n_tests++;
          if (act[i] !== e[i]) begin
            n_fail++;
            $display("FAIL inst%0d t=%0t outputs: got pass=%0b err=%0b step=%0d busy=%0b pcnt=%0d fcnt=%0d ffv=%0b ffs=%0d, want pass=%0b err=%0b step=%0d busy=%0b pcnt=%0d fcnt=%0d ffv=%0b ffs=%0d",
                     i, $time, act[i].pass, act[i].fail, act[i].fstep, act[i].busy,
                     act[i].pcnt, act[i].fcnt, act[i].ffv, act[i].ffs,
                     e[i].pass, e[i].fail, e[i].fstep, e[i].busy,
                     e[i].pcnt, e[i].fcnt, e[i].ffv, e[i].ffs);
          end else if (e[i].pass || e[i].fail) begin
            $display("[TB] inst%0d t=%0t pulse pass=%0b err=%0b step=%0d pcnt=%0d fcnt=%0d ok",
                     i, $time, e[i].pass, e[i].fail, e[i].fstep, e[i].pcnt, e[i].fcnt);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic       r;
    logic       c;
    logic       e;
    logic       t;
    logic [3:0] v;
    rst  = 1'b1;
    clr  = 1'b0;
    en   = 1'b0;
    trig = 1'b0;
    vect = 4'h0;
    for (int i = 0; i < 3; i++) m[i] = '0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

    // Single successful attempt.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    idle(5);

    // Bit 1 low on the third check.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b1101);
    idle(4);

    // Two overlapping attempts launched back to back.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    idle(5);

    // trig with en low launches nothing.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    idle(2);

    // Five passes: saturates the 2-bit counters of instance 0.
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    idle(5);

    // A failure, then clr with a same-cycle trig while attempts are in flight.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    idle(5);

    // rst in the cycle an attempt checks step 2.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'hF);
    idle(5);

    // Randomised traffic, vector bits biased high so attempts can complete.
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 7) != 0);
      t = ($urandom_range(0, 1) == 1);
      for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 7) != 0);
      cyc(r, c, e, t, v);
    end
    idle(6);

    @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_chain_checker.md
SEQ_CHAIN_CHECKER -- requirements
Module: seq_chain_checker

Interface
REQ-001 Parameter WIDTH, default 8: number of monitored vector bits and chain length; legal range 1..32.
REQ-002 Parameter MODE, default 0: chain order; 0 = descending (bit WIDTH-1 first, bit 0 last), 1 = ascending (bit 0 first).
REQ-003 Parameter CNT_W, default 16: width of pass/fail counters; legal minimum 1.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  enables launching new attempts.
REQ-008 clr  input  1  synchronous clear of attempts, counters and capture.
REQ-009 trig  input  1  launch request for a new attempt.
REQ-010 vect  input  WIDTH  monitored vector.
REQ-011 pass  output  1  one-cycle pulse, an attempt completed.
REQ-012 fail  output  1  one-cycle pulse, at least one attempt failed.
REQ-013 fail_step  output  $clog2(WIDTH)+1  step index of the reported failure.
REQ-014 busy  output  1  any attempt in flight beyond step 0.
REQ-015 pass_cnt, fail_cnt  output  CNT_W each  saturating event counters.
REQ-016 first_fail_vld  output  1  sticky, a failure has been captured.
REQ-017 first_fail_step  output  $clog2(WIDTH)+1  step of first captured failure.

Function
REQ-018 Elaboration SHALL raise $error for WIDTH<1, WIDTH>32, MODE not in {0,1}, or CNT_W<1.
REQ-019 Step k (0..WIDTH-1) SHALL check bit b(k) = WIDTH-1-k (MODE 0) or k (MODE 1).
REQ-020 An attempt SHALL launch in cycle c when trig & en & ~clr; step k is checked in cycle c+k.
REQ-021 Live vector L[0..WIDTH-1]: L[0] = trig & en & ~clr (combinational); ok_k = L[k] & vect[b(k)]; fail_k = L[k] & ~vect[b(k)]; L[k+1] registered from ok_k.
REQ-022 Overlapping attempts SHALL be tracked independently, one per step position, with no launch limit.
REQ-023 pass SHALL be registered ok_{WIDTH-1} (asserted in cycle c+WIDTH for a successful attempt launched in cycle c).
REQ-024 fail SHALL be registered OR of all fail_k, asserted one cycle after the failing check; a failed attempt is dropped.
REQ-025 fail_step SHALL be the highest failing k (oldest attempt) in that cycle, registered with fail; it holds its value when fail is low.
REQ-026 pass and fail MAY assert in the same cycle (different attempts); both SHALL be reported.
REQ-027 busy SHALL equal registered OR of L[1..WIDTH-1]; it is constant 0 for WIDTH=1.
REQ-028 pass_cnt SHALL increment by 1 per pass pulse, and fail_cnt by 1 per fail pulse (not per failing attempt); both saturate at 2^CNT_W-1.
REQ-029 On the first fail pulse, first_fail_vld SHALL set and first_fail_step SHALL load fail_step; later failures SHALL NOT modify them.
REQ-030 clr SHALL zero L[1..], pass, fail, counters and capture on the next edge; the same-cycle trig SHALL be ignored.
REQ-031 en low SHALL block new launches only; in-flight attempts SHALL complete normally.
REQ-032 trig with en low SHALL have no effect, including on counters.

Reset
REQ-033 rst SHALL take priority over clr and clear L, pass, fail, fail_step, busy, counters, first_fail_vld and first_fail_step to 0.
REQ-034 rst asserted mid-attempt SHALL abort the attempt with no pass or fail reported.

Verification
REQ-035 WIDTH=4, MODE=0: trig at c0; vect[3], vect[2], vect[1], vect[0] high at c0, c1, c2, c3 -> pass at c4; pass_cnt=1.
REQ-036 WIDTH=4, MODE=0: trig at c0; vect[1] low at c2 -> fail at c3, fail_step=2, first_fail_step=2, no pass.
REQ-037 WIDTH=4, MODE=1: trig at c0 and c1, vect all-ones -> pass at c4 and c5, busy high c1..c4.
REQ-038 WIDTH=1: trig with vect=1 -> pass next cycle; trig with vect=0 -> fail, fail_step=0.
REQ-039 CNT_W=2: 5 passing attempts -> pass_cnt=3 (saturated); clr -> all counters and capture 0.
REQ-040 Attempt at step 2 with rst pulsed -> no pass/fail afterward, busy=0; WIDTH=33 -> elaboration $error.
